serial_tx_arbiter: RTL and testbench
====================================

SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 clkEn  in  1  bit-rate enable; state advances only on clk edges with clkEn=1.
REQ-004 req  in  4  per-requester frame request, level-sensitive.
REQ-005 len_in  in  16  payload length for requester i: len_in[4i+3:4i], range 0..15.
REQ-006 data_in  in  60  payload for requester i: data_in[15i+14:15i].
REQ-007 gnt  out  4  one-hot grant, held for the whole frame.
REQ-008 done  out  4  one-clk-cycle pulse on the granted bit at frame end.
REQ-009 SerOut  out  1  serial line; idles at 1.
REQ-010 Busy  out  1  high in every state except IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, START, PORT, LEN, DATA and GAP.
REQ-012 Each non-IDLE state bit SHALL last exactly one clkEn period; with clkEn=0, state, counters, SerOut, gnt and Busy SHALL hold.
REQ-013 In IDLE with any req bit set on a clkEn edge: pick the winner, latch its index, length and payload, drive gnt, and go to START.
REQ-014 START SHALL drive SerOut=0 for one bit.
REQ-015 PORT SHALL drive the 2-bit winner index, MSB first.
REQ-016 LEN SHALL drive the latched 4-bit length L, MSB first.
REQ-017 DATA SHALL drive payload bits [L-1:0], MSB first, counted by a down-counter loaded with L.
REQ-018 L=0 SHALL skip DATA and go LEN->GAP.
REQ-019 GAP SHALL drive SerOut=1 for one bit, then return to IDLE.
REQ-020 Frame length SHALL be 8+L bit periods.
REQ-021 On the GAP->IDLE edge, gnt SHALL go to 0 and done[winner] SHALL pulse for one clk cycle.
REQ-022 SerOut SHALL depend only on registers, never combinationally on inputs.
REQ-023 Changes to req, len_in or data_in after the grant SHALL be ignored until the next arbitration; a frame always completes.
REQ-024 Arbitration SHALL take place only in IDLE, so at least two consecutive 1 bits (GAP, then IDLE) separate frames.
REQ-025 The round-robin pointer SHALL hold the last granted index; the search SHALL start at pointer+1 and wrap from 3 to 0.

Reset
REQ-026 Asserting rst SHALL, without waiting for a clock edge, force:
- state=IDLE, SerOut=1, gnt=0, done=0, Busy=0
- round-robin pointer=3
- all counters and latches=0
REQ-027 Reset mid-frame SHALL abort the frame with no done pulse.

Configuration
REQ-028 With ROUND_ROBIN_EN defined, arbitration SHALL be round-robin as in REQ-025.
REQ-029 Without ROUND_ROBIN_EN, arbitration SHALL be fixed priority: req[0] highest, req[3] lowest, and the pointer SHALL be absent.

Verification
REQ-030 req=0100, len_in[11:8]=3, data_in[44:30]=15'h0005 -> SerOut 0,1,0,0,0,1,1,1,0,1,1 over 11 bit periods; gnt=0100 throughout; done=0100 pulses once.
REQ-031 req=1111 held, ROUND_ROBIN_EN defined -> grants 0001,0010,0100,1000,0001 on consecutive frames; without the macro -> 0001 on every frame.
REQ-032 req=0010, len=0 -> SerOut 0,0,1,0,0,0,0,1 (8 bit periods); done[1] pulses.
REQ-033 rst asserted during DATA -> SerOut=1, gnt=0, Busy=0 immediately; no done pulse; next request produces a full frame.
REQ-034 clkEn low for 5 clk cycles during PORT -> SerOut and state frozen; the frame resumes with an unchanged bit sequence.
REQ-035 req[0] dropped and len_in changed mid-DATA -> frame completes with the latched values.

Source files
------------

// File: rtl/serial_tx_arbiter_if.sv
// Bundle of the arbiter's request, payload, grant and serial-line signals.
// The master modport is the requester side; the slave modport is the arbiter.
interface serial_tx_arbiter_if;
    logic        clkEn;
    logic [3:0]  req;
    logic [15:0] len_in;
    logic [59:0] data_in;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        SerOut;
    logic        Busy;

    modport master (
        output clkEn, req, len_in, data_in,
        input  gnt, done, SerOut, Busy
    );

    modport slave (
        input  clkEn, req, len_in, data_in,
        output gnt, done, SerOut, Busy
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Four-requester arbiter that serialises the winner's frame: start, port, length, payload, gap.
// Define ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (req[0] highest).
module serial_tx_arbiter (
    input  logic                 clk,
    input  logic                 rst,
    serial_tx_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, GAP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  len_q, len_d;
    logic [14:0] data_q, data_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  done_q, done_d;
    logic        ser_q, ser_d;
`ifdef ROUND_ROBIN_EN
    logic [1:0]  ptr_q, ptr_d;
`endif

    logic [3:0]  len_arr  [4];
    logic [14:0] data_arr [4];
    logic [1:0]  win_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_split
            assign len_arr[gi]  = bus.len_in[4*gi +: 4];
            assign data_arr[gi] = bus.data_in[15*gi +: 15];
        end
    endgenerate

    // The last matching candidate in the loop is the highest-priority one.
    always_comb begin
        win_idx = 2'd0;
`ifdef ROUND_ROBIN_EN
        for (int k = 4; k >= 1; k--) begin
            if (bus.req[ptr_q + 2'(k)])
                win_idx = ptr_q + 2'(k);
        end
`else
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[k])
                win_idx = 2'(k);
        end
`endif
    end

    // ser_d is the line value for the bit period the next state begins,
    // so SerOut comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        data_d  = data_q;
        gnt_d   = gnt_q;
        done_d  = 4'b0000;
        ser_d   = ser_q;
`ifdef ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        if (bus.clkEn) begin
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        state_d = START;
                        idx_d   = win_idx;
                        len_d   = len_arr[win_idx];
                        data_d  = data_arr[win_idx];
                        gnt_d   = 4'b0001 << win_idx;
                        cnt_d   = 4'd0;
                        ser_d   = 1'b0;
`ifdef ROUND_ROBIN_EN
                        ptr_d   = win_idx;
`endif
                    end
                end
                START: begin
                    state_d = PORT;
                    cnt_d   = 4'd1;
                    ser_d   = idx_q[1];
                end
                PORT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = 4'd0;
                        ser_d = idx_q[0];
                    end else begin
                        state_d = LEN;
                        cnt_d   = 4'd3;
                        ser_d   = len_q[3];
                    end
                end
                LEN: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                        ser_d = len_q[2'(cnt_q - 4'd1)];
                    end else if (len_q == 4'd0) begin
                        state_d = GAP;
                        ser_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                        cnt_d   = len_q;
                        ser_d   = data_q[len_q - 4'd1];
                    end
                end
                DATA: begin
                    // cnt_q counts payload bits still to send, including the current one.
                    if (cnt_q > 4'd1) begin
                        cnt_d = cnt_q - 4'd1;
                        ser_d = data_q[cnt_q - 4'd2];
                    end else begin
                        state_d = GAP;
                        cnt_d   = 4'd0;
                        ser_d   = 1'b1;
                    end
                end
                GAP: begin
                    state_d = IDLE;
                    ser_d   = 1'b1;
                    gnt_d   = 4'b0000;
                    done_d  = gnt_q;
                end
                default: begin
                    state_d = IDLE;
                    ser_d   = 1'b1;
                    gnt_d   = 4'b0000;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 2'd0;
            len_q   <= 4'd0;
            data_q  <= 15'd0;
            gnt_q   <= 4'b0000;
            done_q  <= 4'b0000;
            ser_q   <= 1'b1;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= 2'd3;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ser_q   <= ser_d;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.SerOut = ser_q;
    assign bus.Busy   = (state_q != IDLE);
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: frame vector table plus freeze, reset and arbitration sequences.
module tb_serial_tx_arbiter;
    logic clk;
    logic rst;

    serial_tx_arbiter_if bus_if ();

    serial_tx_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] len_in;
        logic [59:0] data_in;
        logic [3:0]  exp_gnt;
        logic [22:0] exp_bits;
        int          nbits;
    } vec_t;

    vec_t vecs [5];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request, then checks every bit period of the resulting frame and the done pulse.
    task automatic run_frame(input vec_t v, input int freeze_at, input bit scramble, input string tag);
        logic exp_bit;
        bus_if.req     = v.req;
        bus_if.len_in  = v.len_in;
        bus_if.data_in = v.data_in;
        tick();
        bus_if.req = 4'b0000;
        for (int i = 0; i < v.nbits; i++) begin
            if (i > 0) tick();
            exp_bit = v.exp_bits[v.nbits - 1 - i];
            check($sformatf("%s bit%0d SerOut", tag, i), 64'(bus_if.SerOut), 64'(exp_bit));
            check($sformatf("%s bit%0d gnt", tag, i), 64'(bus_if.gnt), 64'(v.exp_gnt));
            check($sformatf("%s bit%0d Busy", tag, i), 64'(bus_if.Busy), 64'd1);
            check($sformatf("%s bit%0d done", tag, i), 64'(bus_if.done), 64'd0);
            if (i == freeze_at) begin
                bus_if.clkEn = 1'b0;
                repeat (5) begin
                    tick();
                    check($sformatf("%s frozen SerOut", tag), 64'(bus_if.SerOut), 64'(exp_bit));
                    check($sformatf("%s frozen gnt", tag), 64'(bus_if.gnt), 64'(v.exp_gnt));
                end
                bus_if.clkEn = 1'b1;
            end
            if (scramble && i == 9) begin
                bus_if.len_in  = ~v.len_in;
                bus_if.data_in = ~v.data_in;
            end
        end
        tick();
        check($sformatf("%s end done", tag), 64'(bus_if.done), 64'(v.exp_gnt));
        check($sformatf("%s end gnt", tag), 64'(bus_if.gnt), 64'd0);
        check($sformatf("%s end SerOut", tag), 64'(bus_if.SerOut), 64'd1);
        check($sformatf("%s end Busy", tag), 64'(bus_if.Busy), 64'd0);
        tick();
        check($sformatf("%s done cleared", tag), 64'(bus_if.done), 64'd0);
        $display("frame %s: req=%b gnt=%b bits=%0d", tag, v.req, v.exp_gnt, v.nbits);
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        vecs[0] = '{4'b0100, 16'h0300, 60'(15'h0005) << 30, 4'b0100, 23'b0_10_0011_101_1, 11};
        vecs[1] = '{4'b0010, 16'hFF0F, 60'h0FFF_FFFF_FFFF_FFF,  4'b0010, 23'b0_01_0000_1, 8};
        vecs[2] = '{4'b0001, 16'h000F, 60'h5A5A,               4'b0001, 23'b0_00_1111_101101001011010_1, 23};
        vecs[3] = '{4'b1000, 16'h1000, 60'h1 << 45,            4'b1000, 23'b0_11_0001_1_1, 9};
        vecs[4] = '{4'b0110, 16'h0020, 60'h2 << 15,            4'b0010, 23'b0_01_0010_10_1, 10};
`ifdef ROUND_ROBIN_EN
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif

        rst            = 1'b1;
        bus_if.clkEn   = 1'b1;
        bus_if.req     = 4'b0000;
        bus_if.len_in  = 16'h0000;
        bus_if.data_in = 60'h0;
        #2;
        check("reset SerOut", 64'(bus_if.SerOut), 64'd1);
        check("reset gnt", 64'(bus_if.gnt), 64'd0);
        check("reset done", 64'(bus_if.done), 64'd0);
        check("reset Busy", 64'(bus_if.Busy), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int v = 0; v < 5; v++)
            run_frame(vecs[v], -1, 1'b0, $sformatf("vec%0d", v));

        run_frame(vecs[0], 1, 1'b0, "freeze_port");
        run_frame(vecs[2], -1, 1'b1, "mid_data_change");

        // Abort a frame in DATA with an asynchronous reset.
        bus_if.req     = vecs[2].req;
        bus_if.len_in  = vecs[2].len_in;
        bus_if.data_in = vecs[2].data_in;
        tick();
        bus_if.req = 4'b0000;
        repeat (9) tick();
        check("pre-abort Busy", 64'(bus_if.Busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort SerOut", 64'(bus_if.SerOut), 64'd1);
        check("abort gnt", 64'(bus_if.gnt), 64'd0);
        check("abort Busy", 64'(bus_if.Busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            tick();
            check("abort no done", 64'(bus_if.done), 64'd0);
        end
        $display("frame abort: reset in DATA");
        run_frame(vecs[1], -1, 1'b0, "after_abort");

        // Back-to-back frames with all requesters active, pointer freshly reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.len_in  = 16'h0000;
        bus_if.data_in = 60'h0;
        bus_if.req     = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            int waited;
            waited = 0;
            while (bus_if.gnt == 4'b0000 && waited < 20) begin
                tick();
                waited++;
            end
            check($sformatf("all_req frame%0d gnt", f), 64'(bus_if.gnt), 64'(rr_exp[f]));
            waited = 0;
            while (bus_if.done == 4'b0000 && waited < 20) begin
                tick();
                waited++;
            end
            check($sformatf("all_req frame%0d done", f), 64'(bus_if.done), 64'(rr_exp[f]));
            $display("frame all_req%0d: gnt expected %b", f, rr_exp[f]);
        end
        bus_if.req = 4'b0000;
        repeat (12) tick();
        check("final Busy", 64'(bus_if.Busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
